hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX pipeline fields in, stall/flush/MDU controls out.
// The master modport is the pipeline side, and the slave modport is the hazard controller.
`ifndef RF_REG_W
`define RF_REG_W 5
`endif

interface hazard_ctrl_if #(
    parameter int STAT_W = 16
);
    logic [`RF_REG_W-1:0] iIF_ID_ppRs;
    logic [`RF_REG_W-1:0] iIF_ID_ppRt;
    logic                 iIF_ID_ppUsesRt;
    logic                 iID_EX_ppMemRd;
    logic [`RF_REG_W-1:0] iID_EX_ppRt;
    logic                 iEX_BrTaken;
    logic                 iID_MdStart;
    logic                 iID_MdRead;
    logic                 iStatClr;
    logic                 oPCWrEn;
    logic                 oIF_ID_WrEn;
    logic                 oID_EX_Bubble;
    logic                 oIF_ID_Flush;
    logic                 oID_EX_Flush;
    logic                 oMdGo;
    logic                 oMdBusy;
    logic [STAT_W-1:0]    oStallCnt;

    modport master (
        output iIF_ID_ppRs, iIF_ID_ppRt, iIF_ID_ppUsesRt, iID_EX_ppMemRd, iID_EX_ppRt,
               iEX_BrTaken, iID_MdStart, iID_MdRead, iStatClr,
        input  oPCWrEn, oIF_ID_WrEn, oID_EX_Bubble, oIF_ID_Flush, oID_EX_Flush,
               oMdGo, oMdBusy, oStallCnt
    );

    modport slave (
        input  iIF_ID_ppRs, iIF_ID_ppRt, iIF_ID_ppUsesRt, iID_EX_ppMemRd, iID_EX_ppRt,
               iEX_BrTaken, iID_MdStart, iID_MdRead, iStatClr,
        output oPCWrEn, oIF_ID_WrEn, oID_EX_Bubble, oIF_ID_Flush, oID_EX_Flush,
               oMdGo, oMdBusy, oStallCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core.
// It resolves load-use hazards with a one-cycle bubble, squashes IF/ID and ID/EX on a taken
// branch, and tracks MDU occupancy so that mult/div and mfhi/mflo stall while the MDU is busy.
// It also keeps a saturating stall-cycle statistic.
`ifndef RF_REG_W
`define RF_REG_W 5
`endif

module hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int STAT_W  = 16
) (
    input  logic           iClk,
    input  logic           iReset_n,
    hazard_ctrl_if.slave   hz
);
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    localparam logic [5:0]        LAT_LOAD = 6'(MDU_LAT);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    mdState_t          mdState;
    mdState_t          mdStateNxt;
    logic [5:0]        mdCnt;
    logic [5:0]        mdCntNxt;
    logic [STAT_W-1:0] stallCnt;
    logic [STAT_W-1:0] stallCntNxt;

    logic ldUse;
    logic mdBusy;
    logic mdHaz;
    logic stall;
    logic pcWrEn;
    logic ifIdWrEn;
    logic idExBubble;
    logic ifIdFlush;
    logic idExFlush;
    logic mdGo;

    // Register $0 is never a real dependency, and rt only matters when ID actually reads it.
    assign ldUse  = hz.iID_EX_ppMemRd && (hz.iID_EX_ppRt != '0) &&
                    ((hz.iID_EX_ppRt == hz.iIF_ID_ppRs) ||
                     (hz.iIF_ID_ppUsesRt && (hz.iID_EX_ppRt == hz.iIF_ID_ppRt)));
    assign mdBusy = (mdState == MD_BUSY);
    assign mdHaz  = mdBusy && (hz.iID_MdStart || hz.iID_MdRead);
    assign stall  = !hz.iEX_BrTaken && (ldUse || mdHaz);

    // Combinational pipeline controls: reset forces a held pipe, and a taken branch outranks any stall.
    always_comb begin
        pcWrEn     = 1'b0;
        ifIdWrEn   = 1'b0;
        idExBubble = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        mdGo       = 1'b0;
        if (!iReset_n) begin
            pcWrEn     = 1'b0;
            idExBubble = 1'b1;
        end else if (hz.iEX_BrTaken) begin
            pcWrEn     = 1'b1;
            ifIdWrEn   = 1'b1;
            idExBubble = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            mdGo       = 1'b0;
        end else if (stall) begin
            pcWrEn     = 1'b0;
            ifIdWrEn   = 1'b0;
            idExBubble = 1'b1;
            mdGo       = 1'b0;
        end else begin
            pcWrEn     = 1'b1;
            ifIdWrEn   = 1'b1;
            idExBubble = 1'b0;
            mdGo       = hz.iID_MdStart;
        end
    end

    // MDU occupancy next state: load the latency on issue, then count down to idle.
    always_comb begin
        mdStateNxt = mdState;
        mdCntNxt   = mdCnt;
        case (mdState)
            MD_IDLE: begin
                if (mdGo) begin
                    mdStateNxt = MD_BUSY;
                    mdCntNxt   = LAT_LOAD;
                end else begin
                    mdStateNxt = MD_IDLE;
                    mdCntNxt   = mdCnt;
                end
            end
            MD_BUSY: begin
                if (mdCnt <= 6'd1) begin
                    mdStateNxt = MD_IDLE;
                    mdCntNxt   = 6'd0;
                end else begin
                    mdStateNxt = MD_BUSY;
                    mdCntNxt   = mdCnt - 6'd1;
                end
            end
            default: begin
                mdStateNxt = MD_IDLE;
                mdCntNxt   = 6'd0;
            end
        endcase
    end

    // Stall statistic next value: clear wins, otherwise count stall cycles and saturate at all-ones.
    always_comb begin
        stallCntNxt = stallCnt;
        if (hz.iStatClr) begin
            stallCntNxt = '0;
        end else if (stall && (stallCnt != STAT_MAX)) begin
            stallCntNxt = stallCnt + STAT_W'(1);
        end else begin
            stallCntNxt = stallCnt;
        end
    end

    // State registers for the MDU tracker and the statistic.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            mdState  <= MD_IDLE;
            mdCnt    <= 6'd0;
            stallCnt <= '0;
        end else begin
            mdState  <= mdStateNxt;
            mdCnt    <= mdCntNxt;
            stallCnt <= stallCntNxt;
        end
    end

    assign hz.oPCWrEn       = pcWrEn;
    assign hz.oIF_ID_WrEn   = ifIdWrEn;
    assign hz.oID_EX_Bubble = idExBubble;
    assign hz.oIF_ID_Flush  = ifIdFlush;
    assign hz.oID_EX_Flush  = idExFlush;
    assign hz.oMdGo         = mdGo;
    assign hz.oMdBusy       = mdBusy;
    assign hz.oStallCnt     = stallCnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// A stimulus process drives one cycle at a time and pushes the reference model's expectation.
// A monitor pops each expectation on the falling edge and compares it against the DUT outputs.
`ifndef RF_REG_W
`define RF_REG_W 5
`endif

module tb_hazard_ctrl;
    localparam int MDU_LAT  = 4;
    localparam int STAT_W   = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       memRd;
        logic [4:0] exRt;
        logic       br;
        logic       mdStart;
        logic       mdRead;
        logic       clr;
    } stim_t;

    typedef struct {
        logic pcWr;
        logic ifIdWr;
        logic bubble;
        logic ifFlush;
        logic idFlush;
        logic go;
        logic busy;
        int   cnt;
    } exp_t;

    logic iClk = 1'b0;
    logic iReset_n = 1'b0;
    hazard_ctrl_if #(.STAT_W(STAT_W)) hif ();

    hazard_ctrl #(.MDU_LAT(MDU_LAT), .STAT_W(STAT_W)) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .hz       (hif.slave)
    );

    always #5 iClk = ~iClk;

    exp_t sb[$];
    int   nChecks = 0;
    int   nFail   = 0;

    // Reference model state: busy cycles still ahead and the stall statistic, as plain integers.
    int mdRemain  = 0;
    int statModel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge iClk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("oPCWrEn",       32'(hif.oPCWrEn),       32'(e.pcWr));
                chk("oIF_ID_WrEn",   32'(hif.oIF_ID_WrEn),   32'(e.ifIdWr));
                chk("oID_EX_Bubble", 32'(hif.oID_EX_Bubble), 32'(e.bubble));
                chk("oIF_ID_Flush",  32'(hif.oIF_ID_Flush),  32'(e.ifFlush));
                chk("oID_EX_Flush",  32'(hif.oID_EX_Flush),  32'(e.idFlush));
                chk("oMdGo",         32'(hif.oMdGo),         32'(e.go));
                chk("oMdBusy",       32'(hif.oMdBusy),       32'(e.busy));
                chk("oStallCnt",     32'(hif.oStallCnt),     32'(e.cnt));
            end
        end
    end

    // Drive one cycle, push its expected outputs, then advance the model across the rising edge.
    task automatic applyCycle(input stim_t s, input logic rstN);
        exp_t e;
        logic ldUse, mdHaz, stall, go;
        hif.iIF_ID_ppRs     = s.rs;
        hif.iIF_ID_ppRt     = s.rt;
        hif.iIF_ID_ppUsesRt = s.usesRt;
        hif.iID_EX_ppMemRd  = s.memRd;
        hif.iID_EX_ppRt     = s.exRt;
        hif.iEX_BrTaken     = s.br;
        hif.iID_MdStart     = s.mdStart;
        hif.iID_MdRead      = s.mdRead;
        hif.iStatClr        = s.clr;
        iReset_n            = rstN;
        stall = 1'b0;
        go    = 1'b0;
        if (!rstN) begin
            mdRemain  = 0;
            statModel = 0;
            e = '{pcWr: 1'b0, ifIdWr: 1'b0, bubble: 1'b1, ifFlush: 1'b0, idFlush: 1'b0,
                  go: 1'b0, busy: 1'b0, cnt: 0};
        end else begin
            ldUse = s.memRd && (s.exRt != 5'd0) &&
                    ((s.exRt == s.rs) || (s.usesRt && (s.exRt == s.rt)));
            mdHaz = (mdRemain > 0) && (s.mdStart || s.mdRead);
            stall = !s.br && (ldUse || mdHaz);
            go    = s.mdStart && !stall && !s.br;
            e.pcWr    = !stall;
            e.ifIdWr  = !stall;
            e.bubble  = stall;
            e.ifFlush = s.br;
            e.idFlush = s.br;
            e.go      = go;
            e.busy    = (mdRemain > 0);
            e.cnt     = statModel;
        end
        sb.push_back(e);
        @(posedge iClk);
        #1;
        if (rstN) begin
            if (s.clr)                               statModel = 0;
            else if (stall && statModel < STAT_MAX)  statModel = statModel + 1;
            if (go)                                  mdRemain = MDU_LAT;
            else if (mdRemain > 0)                   mdRemain = mdRemain - 1;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rs: 5'd1, rt: 5'd2, usesRt: 1'b0, memRd: 1'b0, exRt: 5'd0,
              br: 1'b0, mdStart: 1'b0, mdRead: 1'b0, clr: 1'b0};
        return s;
    endfunction

    // Watchdog so that a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        stim_t s;
        @(posedge iClk);
        #1;
        applyCycle(idle(), 1'b0);
        applyCycle(idle(), 1'b0);
        applyCycle(idle(), 1'b1);
        s = idle(); s.clr = 1'b1; applyCycle(s, 1'b1);

        // Load-use on rs: one bubble, then normal flow with a stall count of 1.
        s = idle(); s.memRd = 1'b1; s.exRt = 5'd5; s.rs = 5'd5; applyCycle(s, 1'b1);
        s = idle(); s.rs = 5'd5; applyCycle(s, 1'b1);
        // Load-use on rt.
        s = idle(); s.memRd = 1'b1; s.exRt = 5'd9; s.rt = 5'd9; s.usesRt = 1'b1; applyCycle(s, 1'b1);
        // Register $0 and an unused rt never stall.
        s = idle(); s.memRd = 1'b1; s.exRt = 5'd0; s.rs = 5'd0; applyCycle(s, 1'b1);
        s = idle(); s.memRd = 1'b1; s.exRt = 5'd7; s.rt = 5'd7; s.usesRt = 1'b0; applyCycle(s, 1'b1);

        // A mult followed by mflo: 4 stall cycles, with mflo issuing on the 5th.
        s = idle(); s.clr = 1'b1; applyCycle(s, 1'b1);
        s = idle(); s.mdStart = 1'b1; applyCycle(s, 1'b1);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.mdRead = 1'b1; applyCycle(s, 1'b1);
        end
        applyCycle(idle(), 1'b1);

        // A div followed by a mult while busy: stall until idle, then exactly one issue that reloads the counter.
        s = idle(); s.mdStart = 1'b1; applyCycle(s, 1'b1);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.mdStart = 1'b1; applyCycle(s, 1'b1);
        end
        for (int i = 0; i < 5; i++) applyCycle(idle(), 1'b1);

        // A taken branch beats load-use and an MDU start.
        s = idle(); s.br = 1'b1; s.memRd = 1'b1; s.exRt = 5'd3; s.rs = 5'd3; applyCycle(s, 1'b1);
        s = idle(); s.br = 1'b1; s.mdStart = 1'b1; applyCycle(s, 1'b1);
        applyCycle(idle(), 1'b1);

        // Asynchronous reset while the MDU counter holds 3.
        s = idle(); s.mdStart = 1'b1; applyCycle(s, 1'b1);
        applyCycle(idle(), 1'b1);
        applyCycle(idle(), 1'b0);
        applyCycle(idle(), 1'b1);

        // Saturation at 15, clear priority over a concurrent stall, and a branch with a clear.
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.memRd = 1'b1; s.exRt = 5'd4; s.rs = 5'd4; applyCycle(s, 1'b1);
        end
        s = idle(); s.memRd = 1'b1; s.exRt = 5'd4; s.rs = 5'd4; s.clr = 1'b1; applyCycle(s, 1'b1);
        s = idle(); s.memRd = 1'b1; s.exRt = 5'd4; s.rs = 5'd4; applyCycle(s, 1'b1);
        s = idle(); s.br = 1'b1; s.clr = 1'b1; applyCycle(s, 1'b1);
        applyCycle(idle(), 1'b1);

        // Randomized traffic with small register ranges, so that dependencies are frequent.
        for (int i = 0; i < 500; i++) begin
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.usesRt  = 1'($urandom_range(0, 1));
            s.memRd   = ($urandom_range(0, 2) == 0);
            s.exRt    = 5'($urandom_range(0, 3));
            s.br      = ($urandom_range(0, 5) == 0);
            s.mdStart = ($urandom_range(0, 4) == 0);
            s.mdRead  = ($urandom_range(0, 4) == 0);
            s.clr     = ($urandom_range(0, 15) == 0);
            applyCycle(s, ($urandom_range(0, 99) != 0));
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge iClk);
        if (sb.size() > 0) begin
            nChecks++;
            nFail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
